// File: rtl/rs_pkg.sv
// Shared types and helpers for the reservation station array.
// The optional age-ordered issue select is enabled by defining RS_AGE_ORDER_EN.
package rs_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int TAG_WIDTH_DEF = 6;
  localparam int OP_WIDTH_DEF  = 4;
  localparam int TAG_NONE      = 0;
  localparam int MAX_DEPTH     = 32;

  // Widths follow the default configuration; one slot's architectural state.
  typedef struct packed {
    logic                     busy;
    logic [TAG_WIDTH_DEF-1:0] q1;
    logic [XLEN_DEF-1:0]      v1;
    logic [TAG_WIDTH_DEF-1:0] q2;
    logic [XLEN_DEF-1:0]      v2;
    logic [OP_WIDTH_DEF-1:0]  op;
    logic [TAG_WIDTH_DEF-1:0] rob_tag;
  } rs_entry_t;

  function automatic logic [MAX_DEPTH-1:0] lowest_onehot(input logic [MAX_DEPTH-1:0] v);
    return v & (~v + MAX_DEPTH'(1));
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: operand registers, parallel CDB snoop with
// lowest-port priority, and bypass of a broadcast arriving in the allocation cycle.
module rs_entry
  import rs_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 6,
  parameter int OP_WIDTH  = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          alloc_i,
  input  logic                          free_i,
  input  logic [TAG_WIDTH-1:0]          q1_i,
  input  logic [TAG_WIDTH-1:0]          q2_i,
  input  logic [XLEN-1:0]               v1_i,
  input  logic [XLEN-1:0]               v2_i,
  input  logic [OP_WIDTH-1:0]           op_i,
  input  logic [TAG_WIDTH-1:0]          rob_tag_i,
  input  logic [CDB_PORTS-1:0]          cdb_active_i,
  input  logic [CDB_PORTS*TAG_WIDTH-1:0] cdb_tag_i,
  input  logic [CDB_PORTS*XLEN-1:0]     cdb_data_i,
  output logic                          busy_o,
  output logic                          ready_o,
  output logic [XLEN-1:0]               v1_o,
  output logic [XLEN-1:0]               v2_o,
  output logic [OP_WIDTH-1:0]           op_o,
  output logic [TAG_WIDTH-1:0]          rob_tag_o
);

  logic                 busy_q, busy_d;
  logic [TAG_WIDTH-1:0] q1_q, q1_d, q2_q, q2_d, rob_q, rob_d;
  logic [XLEN-1:0]      v1_q, v1_d, v2_q, v2_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic [TAG_WIDTH-1:0] q1_s, q2_s;
  logic [XLEN-1:0]      v1_s, v2_s;

  // Ports are scanned high to low so the lowest matching port is written last.
  function automatic logic [TAG_WIDTH+XLEN-1:0] snoop(input logic [TAG_WIDTH-1:0] q,
                                                      input logic [XLEN-1:0] v);
    logic [TAG_WIDTH-1:0] q_r;
    logic [XLEN-1:0]      v_r;
    q_r = q;
    v_r = v;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_active_i[p] && (q != TAG_WIDTH'(TAG_NONE)) &&
          (cdb_tag_i[p*TAG_WIDTH +: TAG_WIDTH] == q)) begin
        q_r = TAG_WIDTH'(TAG_NONE);
        v_r = cdb_data_i[p*XLEN +: XLEN];
      end
    end
    return {q_r, v_r};
  endfunction

  always_comb begin
    {q1_s, v1_s} = snoop(alloc_i ? q1_i : q1_q, alloc_i ? v1_i : v1_q);
    {q2_s, v2_s} = snoop(alloc_i ? q2_i : q2_q, alloc_i ? v2_i : v2_q);
    busy_d = busy_q;
    q1_d   = q1_q;
    v1_d   = v1_q;
    q2_d   = q2_q;
    v2_d   = v2_q;
    op_d   = op_q;
    rob_d  = rob_q;
    if (flush_i || (free_i && !alloc_i)) begin
      busy_d = 1'b0;
      q1_d   = '0;
      v1_d   = '0;
      q2_d   = '0;
      v2_d   = '0;
      op_d   = '0;
      rob_d  = '0;
    end else if (alloc_i) begin
      busy_d = 1'b1;
      q1_d   = q1_s;
      v1_d   = v1_s;
      q2_d   = q2_s;
      v2_d   = v2_s;
      op_d   = op_i;
      rob_d  = rob_tag_i;
    end else if (busy_q) begin
      q1_d = q1_s;
      v1_d = v1_s;
      q2_d = q2_s;
      v2_d = v2_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      q1_q   <= '0;
      v1_q   <= '0;
      q2_q   <= '0;
      v2_q   <= '0;
      op_q   <= '0;
      rob_q  <= '0;
    end else begin
      busy_q <= busy_d;
      q1_q   <= q1_d;
      v1_q   <= v1_d;
      q2_q   <= q2_d;
      v2_q   <= v2_d;
      op_q   <= op_d;
      rob_q  <= rob_d;
    end
  end

  assign busy_o    = busy_q;
  assign ready_o   = busy_q && (q1_q == TAG_WIDTH'(TAG_NONE)) && (q2_q == TAG_WIDTH'(TAG_NONE));
  assign v1_o      = v1_q;
  assign v2_o      = v2_q;
  assign op_o      = op_q;
  assign rob_tag_o = rob_q;

endmodule

// File: rtl/reservation_station_array.sv
// DEPTH-entry reservation station: free-slot allocation, issue select and handshake.
// Define RS_AGE_ORDER_EN to issue the oldest ready entry instead of the lowest index.
module reservation_station_array
  import rs_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 6,
  parameter int DEPTH     = 4,
  parameter int CDB_PORTS = 2,
  parameter int OP_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [TAG_WIDTH-1:0]           q1_in,
  input  logic [TAG_WIDTH-1:0]           q2_in,
  input  logic [XLEN-1:0]                v1_in,
  input  logic [XLEN-1:0]                v2_in,
  input  logic [OP_WIDTH-1:0]            op_in,
  input  logic [TAG_WIDTH-1:0]           rob_tag_in,
  input  logic [CDB_PORTS-1:0]           cdb_active,
  input  logic [CDB_PORTS*TAG_WIDTH-1:0] cdb_tag,
  input  logic [CDB_PORTS*XLEN-1:0]      cdb_data,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [XLEN-1:0]                issue_v1,
  output logic [XLEN-1:0]                issue_v2,
  output logic [OP_WIDTH-1:0]            issue_op,
  output logic [TAG_WIDTH-1:0]           issue_rob_tag,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     busy, ready, alloc_sel, issue_sel, alloc_we, free_we;
  logic [MAX_DEPTH-1:0] free_vec;
  logic [XLEN-1:0]      ent_v1 [DEPTH];
  logic [XLEN-1:0]      ent_v2 [DEPTH];
  logic [OP_WIDTH-1:0]  ent_op [DEPTH];
  logic [TAG_WIDTH-1:0] ent_rob [DEPTH];
  logic                 alloc_fire, issue_fire;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      rs_entry #(
        .XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .OP_WIDTH(OP_WIDTH), .CDB_PORTS(CDB_PORTS)
      ) u_entry (
        .clk(clk), .reset(reset), .flush_i(flush),
        .alloc_i(alloc_we[gi]), .free_i(free_we[gi]),
        .q1_i(q1_in), .q2_i(q2_in), .v1_i(v1_in), .v2_i(v2_in),
        .op_i(op_in), .rob_tag_i(rob_tag_in),
        .cdb_active_i(cdb_active), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .busy_o(busy[gi]), .ready_o(ready[gi]),
        .v1_o(ent_v1[gi]), .v2_o(ent_v2[gi]), .op_o(ent_op[gi]), .rob_tag_o(ent_rob[gi])
      );
    end
  endgenerate

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + CNT_W'(busy[i]);
  end

  always_comb begin
    free_vec = '0;
    free_vec[DEPTH-1:0] = ~busy;
    alloc_sel = DEPTH'(lowest_onehot(free_vec));
  end

  assign alloc_ready = (occupancy != CNT_W'(DEPTH));
  assign issue_valid = |ready;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign issue_fire  = issue_valid && issue_ready && !flush;
  assign alloc_we    = alloc_fire ? alloc_sel : '0;
  assign free_we     = issue_fire ? issue_sel : '0;

`ifdef RS_AGE_ORDER_EN
  // age_q[i][j] set means entry j was allocated before entry i.
  logic [DEPTH-1:0] age_q [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age_sel
      assign issue_sel[gi] = ready[gi] && ((age_q[gi] & ready) == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_we[i])     age_q[i] <= busy & ~free_we;
        else if (free_we[i]) age_q[i] <= '0;
        else                 age_q[i] <= age_q[i] & ~free_we & ~alloc_we;
      end
    end
  end
`else
  logic [MAX_DEPTH-1:0] ready_vec;

  always_comb begin
    ready_vec = '0;
    ready_vec[DEPTH-1:0] = ready;
    issue_sel = DEPTH'(lowest_onehot(ready_vec));
  end
`endif

  always_comb begin
    issue_v1      = '0;
    issue_v2      = '0;
    issue_op      = '0;
    issue_rob_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_sel[i]) begin
        issue_v1      = issue_v1 | ent_v1[i];
        issue_v2      = issue_v2 | ent_v2[i];
        issue_op      = issue_op | ent_op[i];
        issue_rob_tag = issue_rob_tag | ent_rob[i];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station_array.sv
// Self-checking bench for reservation_station_array: directed scenarios followed by
// random traffic, all compared against a slot-level reference model.
module tb_reservation_station_array;
  import rs_pkg::*;

  localparam int XLEN = 32, TW = 6, DEPTH = 4, NP = 2, OW = 4;

  logic              clk = 1'b0;
  logic              reset, flush, alloc_valid, alloc_ready, issue_valid, issue_ready;
  logic [TW-1:0]     q1_in, q2_in, rob_tag_in, issue_rob_tag;
  logic [XLEN-1:0]   v1_in, v2_in, issue_v1, issue_v2;
  logic [OW-1:0]     op_in, issue_op;
  logic [NP-1:0]     cdb_active;
  logic [NP*TW-1:0]  cdb_tag;
  logic [NP*XLEN-1:0] cdb_data;
  logic [2:0]        occupancy;

  always #5 clk = ~clk;

  reservation_station_array #(
    .XLEN(XLEN), .TAG_WIDTH(TW), .DEPTH(DEPTH), .CDB_PORTS(NP), .OP_WIDTH(OW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .q1_in(q1_in), .q2_in(q2_in), .v1_in(v1_in), .v2_in(v2_in),
    .op_in(op_in), .rob_tag_in(rob_tag_in),
    .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_op(issue_op),
    .issue_rob_tag(issue_rob_tag), .occupancy(occupancy)
  );

  // Reference model: one record per slot plus an allocation sequence number.
  rs_entry_t   m [DEPTH];
  int unsigned m_seq [DEPTH];
  int unsigned seq_ctr;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_occ();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) c++;
    return c;
  endfunction

  function automatic bit m_rdy(input int i);
    return m[i].busy && m[i].q1 == 0 && m[i].q2 == 0;
  endfunction

  function automatic int m_sel();
    int s = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_rdy(i)) begin
`ifdef RS_AGE_ORDER_EN
        if (s < 0 || m_seq[i] < m_seq[s]) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    return s;
  endfunction

  function automatic void m_snoop(inout logic [TW-1:0] q, inout logic [XLEN-1:0] v);
    if (q == 0) return;
    for (int p = 0; p < NP; p++) begin
      if (cdb_active[p] && cdb_tag[p*TW +: TW] == q) begin
        q = 0;
        v = cdb_data[p*XLEN +: XLEN];
        return;
      end
    end
  endfunction

  task automatic m_advance();
    int s, fs;
    logic [TW-1:0]   a_q1, a_q2;
    logic [XLEN-1:0] a_v1, a_v2;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      return;
    end
    s  = m_sel();
    fs = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].busy) fs = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy) begin
        m_snoop(m[i].q1, m[i].v1);
        m_snoop(m[i].q2, m[i].v2);
      end
    end
    if (s >= 0 && issue_ready) m[s] = '0;
    if (alloc_valid && fs >= 0) begin
      a_q1 = q1_in; a_v1 = v1_in; a_q2 = q2_in; a_v2 = v2_in;
      m_snoop(a_q1, a_v1);
      m_snoop(a_q2, a_v2);
      m[fs].busy = 1'b1;
      m[fs].q1 = a_q1; m[fs].v1 = a_v1;
      m[fs].q2 = a_q2; m[fs].v2 = a_v2;
      m[fs].op = op_in; m[fs].rob_tag = rob_tag_in;
      m_seq[fs] = seq_ctr++;
    end
  endtask

  task automatic check_outputs();
    int s = m_sel();
    check("alloc_ready", alloc_ready, m_occ() != DEPTH);
    check("occupancy", occupancy, m_occ());
    check("issue_valid", issue_valid, s >= 0);
    if (s >= 0) begin
      check("issue_v1", issue_v1, m[s].v1);
      check("issue_v2", issue_v2, m[s].v2);
      check("issue_op", issue_op, m[s].op);
      check("issue_rob_tag", issue_rob_tag, m[s].rob_tag);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    check_outputs();
    m_advance();
    @(negedge clk);
  endtask

  task automatic idle(input logic ir);
    flush = 0; alloc_valid = 0; issue_ready = ir;
    q1_in = 0; q2_in = 0; v1_in = 0; v2_in = 0; op_in = 0; rob_tag_in = 0;
    cdb_active = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic alloc_in(input logic [TW-1:0] q1, input logic [XLEN-1:0] v1,
                          input logic [TW-1:0] q2, input logic [XLEN-1:0] v2,
                          input logic [OW-1:0] op, input logic [TW-1:0] rob);
    alloc_valid = 1; q1_in = q1; v1_in = v1; q2_in = q2; v2_in = v2;
    op_in = op; rob_tag_in = rob;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m[i] = '0; m_seq[i] = 0; end
    seq_ctr = 0;
    reset = 0;
    idle(1'b1);
    alloc_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_issue_v1", issue_v1, 0);
    check("rst_issue_rob", issue_rob_tag, 0);
    @(negedge clk);
    reset = 1;
    idle(1'b1);

    // Ready-on-arrival instruction issues the cycle after allocation.
    alloc_in(0, 5, 0, 7, 0, 3);
    cycle();
    idle(1'b1);
    #1;
    check("t1_valid", issue_valid, 1);
    check("t1_v1", issue_v1, 5);
    check("t1_v2", issue_v2, 7);
    check("t1_rob", issue_rob_tag, 3);
    cycle();
    #1 check("t1_occ_after", occupancy, 0);

    // Operand woken by CDB port 1 two cycles after allocation.
    idle(1'b0);
    alloc_in(9, 0, 0, 32'h22, 4'h2, 10);
    cycle();
    idle(1'b0);
    cycle();
    cdb_active = 2'b10; cdb_tag[TW +: TW] = 9; cdb_data[XLEN +: XLEN] = 32'hAB;
    #1 check("t2_not_yet", issue_valid, 0);
    cycle();
    idle(1'b1);
    #1;
    check("t2_valid", issue_valid, 1);
    check("t2_v1", issue_v1, 32'hAB);
    cycle();

    // Broadcast in the allocation cycle is captured by the bypass.
    idle(1'b0);
    alloc_in(0, 1, 4, 0, 4'h5, 11);
    cdb_active = 2'b01; cdb_tag[0 +: TW] = 4; cdb_data[0 +: XLEN] = 32'h11;
    cycle();
    idle(1'b1);
    #1;
    check("t3_valid", issue_valid, 1);
    check("t3_v2", issue_v2, 32'h11);
    cycle();

    // Fill every slot, then try one more allocation.
    for (int i = 0; i < DEPTH; i++) begin
      idle(1'b0);
      alloc_in(7, 32'h100 + i, 0, i, 4'(i), 6'(20 + i));
      cycle();
    end
    idle(1'b0);
    alloc_in(0, 0, 0, 0, 0, 24);
    #1;
    check("t4_full_ready", alloc_ready, 0);
    check("t4_full_occ", occupancy, 4);
    cycle();
    idle(1'b0);
    cdb_active = 2'b10; cdb_tag[TW +: TW] = 7; cdb_data[XLEN +: XLEN] = 32'h77;
    #1 check("t4_still_full", occupancy, 4);
    cycle();
    idle(1'b1);
    cycle();
    idle(1'b0);
    #1;
    check("t4_freed_ready", alloc_ready, 1);
    check("t4_freed_occ", occupancy, 3);

    // Flush wins over simultaneous allocation and issue.
    flush = 1; issue_ready = 1;
    alloc_in(0, 9, 0, 9, 1, 30);
    cycle();
    idle(1'b0);
    #1;
    check("t5_occ", occupancy, 0);
    check("t5_valid", issue_valid, 0);
    cycle();

    // Older entry in a higher slot versus a younger one in slot 0.
    alloc_in(0, 1, 0, 1, 0, 40);
    cycle();
    idle(1'b1);
    alloc_in(5, 0, 0, 2, 0, 41);
    cycle();
    idle(1'b0);
    alloc_in(6, 0, 0, 3, 0, 42);
    cycle();
    idle(1'b0);
    cdb_active = 2'b11; cdb_tag = {6'd6, 6'd5}; cdb_data = {32'h66, 32'h55};
    cycle();
    idle(1'b1);
`ifdef RS_AGE_ORDER_EN
    #1 check("t6_first", issue_rob_tag, 41);
`else
    #1 check("t6_first", issue_rob_tag, 42);
`endif
    cycle();
    idle(1'b1);
    cycle();
    idle(1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      flush       = ($urandom_range(0, 99) < 2);
      alloc_valid = ($urandom_range(0, 99) < 60);
      q1_in       = $urandom_range(0, 1) ? 6'd0 : 6'($urandom_range(1, 7));
      q2_in       = $urandom_range(0, 1) ? 6'd0 : 6'($urandom_range(1, 7));
      v1_in       = $urandom;
      v2_in       = $urandom;
      op_in       = 4'($urandom);
      rob_tag_in  = 6'($urandom);
      cdb_active  = 2'($urandom);
      for (int p = 0; p < NP; p++) begin
        cdb_tag[p*TW +: TW]     = 6'($urandom_range(0, 7));
        cdb_data[p*XLEN +: XLEN] = $urandom;
      end
      issue_ready = ($urandom_range(0, 99) < 45);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
